// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
//
// Shares the single 7-segment digit between four 4-bit greenhouse readings.
// Valid sources take turns on the display, DWELL ticks each. Any source can
// take over the display with a blinking alert through a level request /
// one-hot grant handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   src         four 4-bit readings, source i = src[4i+3:4i]
//   src_valid   source i takes part in rotation when set
//   alert_req   level alert request per source
//   hold        freezes rotation (no effect during an alert)
//   alert_gnt   one-hot alert grant (registered)
//   disp_value  value for val_to_seven_seg (registered)
//   disp_blank  digit blank request (registered)
//   cur_src     index currently shown (registered)
//   tick        one-cycle pulse, once every TICK_DIV cycles (registered)
module seg_display_scheduler #(
    parameter int TICK_DIV    = 25_000_000,
    parameter int DWELL       = 3,
    parameter int ALERT_TICKS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] src,
    input  logic [3:0]  src_valid,
    input  logic [3:0]  alert_req,
    input  logic        hold,
    output logic [3:0]  alert_gnt,
    output logic [3:0]  disp_value,
    output logic        disp_blank,
    output logic [1:0]  cur_src,
    output logic        tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    // tick is registered, so it is raised one count early to line up with
    // the cycle in which the prescaler holds TICK_DIV-1.
    localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
    localparam logic [7:0]    DWELL_LIM  = 8'(DWELL);
    localparam logic [7:0]    ALERT_LIM  = 8'(ALERT_TICKS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROTATE = 2'd1;
    localparam logic [1:0] ST_ALERT  = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg;
    logic          tick_reg;
    logic [7:0]    dwell_reg, dwell_next;
    logic [7:0]    acnt_reg, acnt_next;
    logic [3:0]    elig_reg, elig_next;
    logic [3:0]    gnt_reg, gnt_next;
    logic [1:0]    cur_reg, cur_next;
    logic [3:0]    value_reg, value_next;
    logic          blank_reg, blank_next;

    logic [3:0]    eligible;
    logic [1:0]    win_idx;
    logic [1:0]    first_valid;
    logic [3:0]    src_arr [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        assign src_arr[gi]  = src[4*gi +: 4];
        assign eligible[gi] = alert_req[gi] & elig_reg[gi];
    end

    // Lowest set index of v (0 when v is empty).
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // First set index strictly after cur, searching cyclically upward; wraps
    // back to cur itself when it is the only one set.
    function automatic logic [1:0] next_after(input logic [3:0] v, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        r = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (v[idx]) r = idx;
        end
        return r;
    endfunction

    assign win_idx     = lowest_idx(eligible);
    assign first_valid = lowest_idx(src_valid);

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        dwell_next = dwell_reg;
        acnt_next  = acnt_reg;
        gnt_next   = gnt_reg;
        blank_next = blank_reg;
        // A low request re-arms its eligibility.
        elig_next  = elig_reg | ~alert_req;

        case (state_reg)
            ST_ALERT: begin
                if (!alert_req[cur_reg] || (tick_reg && (acnt_reg + 8'd1 == ALERT_LIM))) begin
                    gnt_next   = 4'b0000;
                    acnt_next  = 8'd0;
                    dwell_next = 8'd0;
                    if (src_valid != 4'b0000) begin
                        state_next = ST_ROTATE;
                        cur_next   = first_valid;
                        blank_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        cur_next   = 2'd0;
                        blank_next = 1'b1;
                    end
                end else if (tick_reg) begin
                    acnt_next  = acnt_reg + 8'd1;
                    blank_next = ~blank_reg;
                end
            end
            default: begin
                // IDLE and ROTATE share the priority chain: alert entry first,
                // then loss of all sources, then entry/advance of rotation.
                if (eligible != 4'b0000) begin
                    state_next = ST_ALERT;
                    cur_next   = win_idx;
                    gnt_next   = 4'b0001 << win_idx;
                    acnt_next  = 8'd0;
                    blank_next = 1'b0;
                    elig_next  = elig_next & ~(4'b0001 << win_idx);
                end else if (src_valid == 4'b0000) begin
                    state_next = ST_IDLE;
                    cur_next   = 2'd0;
                    dwell_next = 8'd0;
                    blank_next = 1'b1;
                end else if (state_reg != ST_ROTATE) begin
                    state_next = ST_ROTATE;
                    cur_next   = first_valid;
                    dwell_next = 8'd0;
                    blank_next = 1'b0;
                end else if (!src_valid[cur_reg]) begin
                    cur_next   = next_after(src_valid, cur_reg);
                    dwell_next = 8'd0;
                end else if (tick_reg && !hold) begin
                    if (dwell_reg + 8'd1 == DWELL_LIM) begin
                        cur_next   = next_after(src_valid, cur_reg);
                        dwell_next = 8'd0;
                    end else begin
                        dwell_next = dwell_reg + 8'd1;
                    end
                end
            end
        endcase

        value_next = (state_next == ST_IDLE) ? 4'd0 : src_arr[cur_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
            tick_reg  <= 1'b0;
            dwell_reg <= 8'd0;
            acnt_reg  <= 8'd0;
            elig_reg  <= 4'b1111;
            gnt_reg   <= 4'b0000;
            cur_reg   <= 2'd0;
            value_reg <= 4'd0;
            blank_reg <= 1'b1;
        end else begin
            presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
            tick_reg  <= (presc_reg == PRESC_PRE);
            state_reg <= state_next;
            dwell_reg <= dwell_next;
            acnt_reg  <= acnt_next;
            elig_reg  <= elig_next;
            gnt_reg   <= gnt_next;
            cur_reg   <= cur_next;
            value_reg <= value_next;
            blank_reg <= blank_next;
        end
    end

    assign alert_gnt  = gnt_reg;
    assign disp_value = value_reg;
    assign disp_blank = blank_reg;
    assign cur_src    = cur_reg;
    assign tick       = tick_reg;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler with TICK_DIV=4, DWELL=2, ALERT_TICKS=3.
// Expected output words {gnt, value, blank, cur, tick} are pushed when the
// stimulus for an edge is driven and popped after that edge.
module tb_seg_display_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] src;
    logic [3:0]  src_valid;
    logic [3:0]  alert_req;
    logic        hold;
    logic [3:0]  alert_gnt;
    logic [3:0]  disp_value;
    logic        disp_blank;
    logic [1:0]  cur_src;
    logic        tick;

    int checks = 0;
    int passes = 0;
    logic [11:0] exp_q [$];

    seg_display_scheduler #(
        .TICK_DIV    (4),
        .DWELL       (2),
        .ALERT_TICKS (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .src_valid  (src_valid),
        .alert_req  (alert_req),
        .hold       (hold),
        .alert_gnt  (alert_gnt),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .cur_src    (cur_src),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input logic [3:0] g, input logic [3:0] v,
                                       input logic b, input logic [1:0] c, input logic t);
        return {g, v, b, c, t};
    endfunction

    // Tick is high after the n-th edge following reset when n mod 4 == 3.
    function automatic logic tk(input int n);
        return (n % 4) == 3;
    endfunction

    function automatic logic [11:0] obs();
        return {alert_gnt, disp_value, disp_blank, cur_src, tick};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e, o;
        src = 16'h4321; src_valid = 4'hf; alert_req = 4'hf; hold = 1'b0; rst = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            exp_q.push_back(pk(4'h0, 4'h0, 1'b1, 2'd0, 1'b0));
            step();
            e = exp_q.pop_front(); o = obs(); checks++;
            if (o !== e) $display("FAIL reset n=%0d got %b exp %b (gnt_val_blank_cur_tick)", n, o, e);
            else begin passes++; $display("reset n=%0d ok %b", n, o); end
        end
        rst = 1'b0; alert_req = 4'h0;
    endtask

    task automatic test_rotation();
        logic [11:0] e, o;
        logic [3:0] v;
        src = 16'h4321; src_valid = 4'hf; alert_req = 4'h0; hold = 1'b0;
        do_reset();
        for (int n = 1; n <= 35; n++) begin
            v = (n < 8) ? 4'd1 : (n < 16) ? 4'd2 : (n < 24) ? 4'd3 : (n < 32) ? 4'd4 : 4'd1;
            exp_q.push_back(pk(4'h0, v, 1'b0, 2'(v - 4'd1), tk(n)));
            step();
            e = exp_q.pop_front(); o = obs(); checks++;
            if (o !== e) $display("FAIL rotation n=%0d got %b exp %b (gnt_val_blank_cur_tick)", n, o, e);
            else begin passes++; $display("rotation n=%0d ok %b", n, o); end
        end
    endtask

    task automatic test_invalid_drop();
        logic [11:0] e, o;
        src = 16'h4321; alert_req = 4'h0; hold = 1'b0; src_valid = 4'b0101;
        do_reset();
        for (int n = 1; n <= 13; n++) begin
            src_valid = (n <= 10) ? 4'b0101 : (n <= 12) ? 4'b0001 : 4'b0000;
            if (n <= 7)       exp_q.push_back(pk(4'h0, 4'd1, 1'b0, 2'd0, tk(n)));
            else if (n <= 10) exp_q.push_back(pk(4'h0, 4'd3, 1'b0, 2'd2, tk(n)));
            else if (n <= 12) exp_q.push_back(pk(4'h0, 4'd1, 1'b0, 2'd0, tk(n)));
            else              exp_q.push_back(pk(4'h0, 4'd0, 1'b1, 2'd0, tk(n)));
            step();
            e = exp_q.pop_front(); o = obs(); checks++;
            if (o !== e) $display("FAIL invalid_drop n=%0d got %b exp %b (gnt_val_blank_cur_tick)", n, o, e);
            else begin passes++; $display("invalid_drop n=%0d ok %b", n, o); end
        end
    endtask

    task automatic test_alert();
        logic [11:0] e, o;
        src = 16'h4321; src_valid = 4'hf; alert_req = 4'h0; hold = 1'b0;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            alert_req = (n >= 5) ? 4'b1010 : 4'b0000;
            if (n <= 4)       exp_q.push_back(pk(4'h0,    4'd1, 1'b0, 2'd0, tk(n)));
            else if (n <= 7)  exp_q.push_back(pk(4'b0010, 4'd2, 1'b0, 2'd1, tk(n)));
            else if (n <= 11) exp_q.push_back(pk(4'b0010, 4'd2, 1'b1, 2'd1, tk(n)));
            else if (n <= 15) exp_q.push_back(pk(4'b0010, 4'd2, 1'b0, 2'd1, tk(n)));
            else if (n == 16) exp_q.push_back(pk(4'h0,    4'd1, 1'b0, 2'd0, tk(n)));
            else if (n <= 19) exp_q.push_back(pk(4'b1000, 4'd4, 1'b0, 2'd3, tk(n)));
            else              exp_q.push_back(pk(4'b1000, 4'd4, 1'b1, 2'd3, tk(n)));
            step();
            e = exp_q.pop_front(); o = obs(); checks++;
            if (o !== e) $display("FAIL alert n=%0d got %b exp %b (gnt_val_blank_cur_tick)", n, o, e);
            else begin passes++; $display("alert n=%0d ok %b", n, o); end
        end
        alert_req = 4'h0;
    endtask

    task automatic test_no_regrant();
        logic [11:0] e, o;
        src = 16'h4321; src_valid = 4'hf; alert_req = 4'b0010; hold = 1'b0;
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            alert_req = (n == 17) ? 4'b0000 : 4'b0010;
            if (n <= 3)       exp_q.push_back(pk(4'b0010, 4'd2, 1'b0, 2'd1, tk(n)));
            else if (n <= 7)  exp_q.push_back(pk(4'b0010, 4'd2, 1'b1, 2'd1, tk(n)));
            else if (n <= 11) exp_q.push_back(pk(4'b0010, 4'd2, 1'b0, 2'd1, tk(n)));
            else if (n <= 17) exp_q.push_back(pk(4'h0,    4'd1, 1'b0, 2'd0, tk(n)));
            else              exp_q.push_back(pk(4'b0010, 4'd2, 1'b0, 2'd1, tk(n)));
            step();
            e = exp_q.pop_front(); o = obs(); checks++;
            if (o !== e) $display("FAIL no_regrant n=%0d got %b exp %b (gnt_val_blank_cur_tick)", n, o, e);
            else begin passes++; $display("no_regrant n=%0d ok %b", n, o); end
        end
        alert_req = 4'h0;
    endtask

    task automatic test_hold();
        logic [11:0] e, o;
        src = 16'h4321; src_valid = 4'hf; alert_req = 4'h0; hold = 1'b1;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            hold      = (n <= 22);
            alert_req = (n == 21) ? 4'b0100 : 4'b0000;
            if (n <= 20)      exp_q.push_back(pk(4'h0,    4'd1, 1'b0, 2'd0, tk(n)));
            else if (n == 21) exp_q.push_back(pk(4'b0100, 4'd3, 1'b0, 2'd2, tk(n)));
            else if (n <= 27) exp_q.push_back(pk(4'h0,    4'd1, 1'b0, 2'd0, tk(n)));
            else              exp_q.push_back(pk(4'h0,    4'd2, 1'b0, 2'd1, tk(n)));
            step();
            e = exp_q.pop_front(); o = obs(); checks++;
            if (o !== e) $display("FAIL hold n=%0d got %b exp %b (gnt_val_blank_cur_tick)", n, o, e);
            else begin passes++; $display("hold n=%0d ok %b", n, o); end
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_in_alert();
        logic [11:0] e, o;
        int m;
        src = 16'h4321; src_valid = 4'hf; alert_req = 4'b0001; hold = 1'b0;
        do_reset();
        for (int n = 1; n <= 11; n++) begin
            rst = (n == 6);
            m = n - 6;
            if (n <= 3)       exp_q.push_back(pk(4'b0001, 4'd1, 1'b0, 2'd0, tk(n)));
            else if (n <= 5)  exp_q.push_back(pk(4'b0001, 4'd1, 1'b1, 2'd0, tk(n)));
            else if (n == 6)  exp_q.push_back(pk(4'h0,    4'd0, 1'b1, 2'd0, 1'b0));
            else if (m <= 3)  exp_q.push_back(pk(4'b0001, 4'd1, 1'b0, 2'd0, tk(m)));
            else              exp_q.push_back(pk(4'b0001, 4'd1, 1'b1, 2'd0, tk(m)));
            step();
            e = exp_q.pop_front(); o = obs(); checks++;
            if (o !== e) $display("FAIL reset_in_alert n=%0d got %b exp %b (gnt_val_blank_cur_tick)", n, o, e);
            else begin passes++; $display("reset_in_alert n=%0d ok %b", n, o); end
        end
        rst = 1'b0; alert_req = 4'h0;
    endtask

    initial begin
        rst = 1'b1; src = 16'h0; src_valid = 4'h0; alert_req = 4'h0; hold = 1'b0;
        test_reset();
        test_rotation();
        test_invalid_drop();
        test_alert();
        test_no_regrant();
        test_hold();
        test_reset_in_alert();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
